// File: rtl/deinterleave_sched_pkg.sv
// Shared types and rate decode for the deinterleave scheduler and the deinterleaver.
// Covers the FSM state enum, the N_DC constants, the modulation enum and the rate-to-N_BPSC decode.
package deinterleave_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MOD_BPSK  = 2'd0,
      MOD_QPSK  = 2'd1,
      MOD_QAM16 = 2'd2,
      MOD_QAM64 = 2'd3
   } mod_e;

   localparam logic [5:0] N_DC_LEGACY = 6'd48;
   localparam logic [5:0] N_DC_HT     = 6'd52;

   typedef struct packed {
      logic supported;
      mod_e modulation;
   } rate_dec_t;

   // Legacy codes follow the 802.11a SIGNAL rate field; HT codes are MCS 0-7; bits 6:4 are reserved and must be 0
   function automatic rate_dec_t decode_rate(input logic [7:0] rate);
      rate_dec_t res;
      res.supported  = (rate[6:4] == 3'b000);
      res.modulation = MOD_BPSK;
      if (rate[7]) begin
         case (rate[3:0])
            4'd0:             res.modulation = MOD_BPSK;
            4'd1, 4'd2:       res.modulation = MOD_QPSK;
            4'd3, 4'd4:       res.modulation = MOD_QAM16;
            4'd5, 4'd6, 4'd7: res.modulation = MOD_QAM64;
            default:          res.supported  = 1'b0;
         endcase
      end else begin
         case (rate[3:0])
            4'hB, 4'hF: res.modulation = MOD_BPSK;
            4'hA, 4'hE: res.modulation = MOD_QPSK;
            4'h9, 4'hD: res.modulation = MOD_QAM16;
            4'h8, 4'hC: res.modulation = MOD_QAM64;
            default:    res.supported  = 1'b0;
         endcase
      end
      return res;
   endfunction

   function automatic logic [2:0] mod_to_nbpsc(input mod_e m);
      case (m)
         MOD_BPSK:  return 3'd1;
         MOD_QPSK:  return 3'd2;
         MOD_QAM16: return 3'd4;
         MOD_QAM64: return 3'd6;
         default:   return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/deinterleave_sched_if.sv
// Handshake and control bundle between the deinterleave scheduler and its environment.
interface deinterleave_sched_if #(parameter int SYM_W = 16);
   logic             enable;
   logic             start;
   logic [7:0]       rate;
   logic [SYM_W-1:0] num_sym;
   logic             in_strobe;
   logic             in_ready;
   logic             deint_strobe;
   logic             deint_out_strobe;
   logic             sym_done;
   logic             pkt_done;
   logic             busy;
   logic [1:0]       err;

   modport master (
      output enable, start, rate, num_sym, in_strobe, deint_out_strobe,
      input  in_ready, deint_strobe, sym_done, pkt_done, busy, err
   );

   modport slave (
      input  enable, start, rate, num_sym, in_strobe, deint_out_strobe,
      output in_ready, deint_strobe, sym_done, pkt_done, busy, err
   );
endinterface

// File: rtl/deinterleave_sched_rate_decode.sv
// deint_rate_decode: captures N_BPSC, N_DC and the supported flag at start and
// derives the drain target (N_CBPS/2 output strobes) from the captured values.
module deint_rate_decode
   import deinterleave_sched_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       en_i,
   input  logic       load_i,
   input  logic [7:0] rate_i,
   output logic [5:0] n_dc_o,
   output logic [8:0] drain_target_o,
   output logic       supported_o
);

   rate_dec_t  dec_s;
   logic [2:0] n_bpsc_q;
   logic [5:0] n_dc_q;
   logic       sup_q;
   logic [8:0] drain_q;
   logic [8:0] ncbps_s;

   assign dec_s   = decode_rate(rate_i);
   assign ncbps_s = 9'(n_dc_q) * 9'(n_bpsc_q);

   // The drain target settles one enabled cycle after load, long before the first symbol finishes filling
   always_ff @(posedge clock) begin
      if (reset) begin
         n_bpsc_q <= 3'd0;
         n_dc_q   <= 6'd0;
         sup_q    <= 1'b0;
         drain_q  <= 9'd0;
      end else if (en_i) begin
         if (load_i) begin
            n_bpsc_q <= mod_to_nbpsc(dec_s.modulation);
            n_dc_q   <= rate_i[7] ? N_DC_HT : N_DC_LEGACY;
            sup_q    <= dec_s.supported;
         end
         drain_q <= {1'b0, ncbps_s[8:1]};
      end
   end

   assign n_dc_o         = n_dc_q;
   assign drain_target_o = drain_q;
   assign supported_o    = sup_q;

endmodule

// File: rtl/deinterleave_sched.sv
// Deinterleaver scheduler: gates one symbol of carriers in (FILL), then waits for the soft-bit drain (DRAIN).
// Optional drain watchdog enabled by defining DEINT_SCHED_TIMEOUT_EN.
module deinterleave_sched
   import deinterleave_sched_pkg::*;
#(
   parameter int SYM_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   deinterleave_sched_if.slave bus
);

   localparam logic [SYM_W-1:0] SYM_ONE = {{(SYM_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [5:0]       car_q, car_d;
   logic [8:0]       drn_q, drn_d;
   logic [SYM_W-1:0] sym_q, sym_d;
   logic [SYM_W-1:0] nsym_q, nsym_d;
   logic             sym_done_q, sym_done_d;
   logic             pkt_done_q, pkt_done_d;
   logic             err_rate_q, err_rate_d;
   logic [5:0]       n_dc_s;
   logic [8:0]       drain_tgt_s;
   logic             cfg_sup_s;
   logic             fwd_s;
   rate_dec_t        start_dec_s;
`ifdef DEINT_SCHED_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic             err_to_q, err_to_d;
`endif

   deint_rate_decode u_rate_decode (
      .clock          (clock),
      .reset          (reset),
      .en_i           (bus.enable),
      .load_i         (bus.start),
      .rate_i         (bus.rate),
      .n_dc_o         (n_dc_s),
      .drain_target_o (drain_tgt_s),
      .supported_o    (cfg_sup_s)
   );

   assign start_dec_s      = decode_rate(bus.rate);
   assign bus.in_ready     = (state_q == ST_FILL) && cfg_sup_s;
   assign fwd_s            = bus.in_strobe & bus.in_ready & bus.enable;
   assign bus.deint_strobe = fwd_s;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.sym_done     = sym_done_q;
   assign bus.pkt_done     = pkt_done_q;
`ifdef DEINT_SCHED_TIMEOUT_EN
   assign bus.err          = {err_to_q, err_rate_q};
`else
   assign bus.err          = {1'b0, err_rate_q};
`endif

   // Next-state and done-pulse logic; everything holds while enable is low
   always_comb begin
      state_d    = state_q;
      car_d      = car_q;
      drn_d      = drn_q;
      sym_d      = sym_q;
      nsym_d     = nsym_q;
      sym_done_d = sym_done_q;
      pkt_done_d = pkt_done_q;
      err_rate_d = err_rate_q;
`ifdef DEINT_SCHED_TIMEOUT_EN
      wdog_d     = wdog_q;
      err_to_d   = err_to_q;
`endif
      if (bus.enable) begin
         sym_done_d = 1'b0;
         pkt_done_d = 1'b0;
         if (bus.start) begin
            car_d      = 6'd0;
            drn_d      = 9'd0;
            sym_d      = '0;
            nsym_d     = bus.num_sym;
            err_rate_d = 1'b0;
`ifdef DEINT_SCHED_TIMEOUT_EN
            wdog_d     = '0;
            err_to_d   = 1'b0;
`endif
            if (bus.num_sym == '0) begin
               pkt_done_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (!start_dec_s.supported) begin
               err_rate_d = 1'b1;
               state_d    = ST_ERROR;
            end else begin
               state_d    = ST_FILL;
            end
         end else begin
            case (state_q)
               ST_FILL: begin
                  if (fwd_s) begin
                     if (car_q == n_dc_s - 6'd1) begin
                        car_d   = 6'd0;
                        state_d = ST_DRAIN;
                     end else begin
                        car_d   = car_q + 6'd1;
                     end
                  end else begin
                     car_d = car_q;
                  end
               end
               ST_DRAIN: begin
                  if (bus.deint_out_strobe) begin
`ifdef DEINT_SCHED_TIMEOUT_EN
                     wdog_d = '0;
`endif
                     if (drn_q + 9'd1 == drain_tgt_s) begin
                        drn_d      = 9'd0;
                        sym_done_d = 1'b1;
                        if (sym_q + SYM_ONE == nsym_q) begin
                           pkt_done_d = 1'b1;
                           sym_d      = '0;
                           state_d    = ST_IDLE;
                        end else begin
                           sym_d      = sym_q + SYM_ONE;
                           state_d    = ST_FILL;
                        end
                     end else begin
                        drn_d = drn_q + 9'd1;
                     end
                  end else begin
`ifdef DEINT_SCHED_TIMEOUT_EN
                     if (wdog_q == WD_LAST) begin
                        wdog_d   = '0;
                        err_to_d = 1'b1;
                        state_d  = ST_ERROR;
                     end else begin
                        wdog_d   = wdog_q + 1'b1;
                     end
`else
                     drn_d = drn_q;
`endif
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         car_q      <= 6'd0;
         drn_q      <= 9'd0;
         sym_q      <= '0;
         nsym_q     <= '0;
         sym_done_q <= 1'b0;
         pkt_done_q <= 1'b0;
         err_rate_q <= 1'b0;
`ifdef DEINT_SCHED_TIMEOUT_EN
         wdog_q     <= '0;
         err_to_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         car_q      <= car_d;
         drn_q      <= drn_d;
         sym_q      <= sym_d;
         nsym_q     <= nsym_d;
         sym_done_q <= sym_done_d;
         pkt_done_q <= pkt_done_d;
         err_rate_q <= err_rate_d;
`ifdef DEINT_SCHED_TIMEOUT_EN
         wdog_q     <= wdog_d;
         err_to_q   <= err_to_d;
`endif
      end
   end

endmodule

// File: doc/deinterleave_sched.md
DEINTERLEAVE_SCHED -- requirements
Module: deinterleave_sched

Interface
REQ-001 Parameter SYM_W, 16, width of symbol counter and num_sym.
REQ-002 Parameter TIMEOUT_CYCLES, 1024, drain watchdog limit in enabled cycles; used only with DEINT_SCHED_TIMEOUT_EN.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global advance; when low, all state, counters and outputs SHALL hold.
REQ-006 start  input  1  one-cycle pulse that begins a packet.
REQ-007 rate  input  8  rate/MCS code; bit7 = HT, bits3:0 = rate index; sampled at start.
REQ-008 num_sym  input  SYM_W  OFDM symbols in packet; sampled at start.
REQ-009 in_strobe  input  1  upstream data carrier valid.
REQ-010 in_ready  output  1  block accepts a carrier this cycle.
REQ-011 deint_strobe  output  1  forwarded carrier strobe to deinterleaver (= in_strobe & in_ready & enable).
REQ-012 deint_out_strobe  input  1  deinterleaver output strobe, one per two soft bits.
REQ-013 sym_done  output  1  one-cycle pulse when a symbol is fully drained.
REQ-014 pkt_done  output  1  one-cycle pulse when the last symbol is drained.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 err  output  2  sticky: bit0 = unsupported rate, bit1 = drain timeout; cleared by start or reset.

Function
REQ-017 States IDLE, FILL, DRAIN, ERROR; the FSM SHALL enter FILL from IDLE on start when num_sym != 0 and the rate is supported.
REQ-018 start with num_sym = 0 SHALL pulse pkt_done the next cycle and remain in IDLE.
REQ-019 start with an unsupported rate SHALL set err[0] and enter ERROR; ERROR SHALL exit to IDLE only on start or reset.
REQ-020 N_DC = 52 if HT else 48; N_BPSC = 1/2/4/6 for BPSK/QPSK/16QAM/64QAM; N_CBPS = N_DC*N_BPSC; drain target = N_CBPS/2 strobes (9-bit counter).
REQ-021 in_ready SHALL be high only in FILL; each deint_strobe SHALL increment a 6-bit carrier counter.
REQ-022 On the deint_strobe with carrier counter = N_DC-1, the counter SHALL reset to 0 and the FSM SHALL enter DRAIN on the next cycle, with in_ready low from that cycle.
REQ-023 In DRAIN each deint_out_strobe SHALL increment the drain counter; on the strobe reaching the drain target, sym_done SHALL pulse on the next cycle and the drain counter SHALL clear.
REQ-024 After the drain completes, if symbol count+1 = num_sym, pkt_done SHALL pulse together with sym_done and the FSM SHALL return to IDLE; otherwise it SHALL re-enter FILL.
REQ-025 deint_out_strobe outside DRAIN SHALL be ignored and SHALL NOT affect the counters.
REQ-026 start while busy SHALL abort the packet, clear all counters, resample rate/num_sym and behave as from IDLE.
REQ-027 sym_done/pkt_done SHALL be registered outputs; the latency from the final deint_out_strobe to sym_done is 1 cycle.

Reset
REQ-028 Reset SHALL force IDLE, clear all counters, and drive in_ready = 0, sym_done = 0, pkt_done = 0, busy = 0, err = 0.
REQ-029 Reset mid-packet SHALL take priority over enable and start and discard the packet without any done pulse.

Configuration
REQ-030 With DEINT_SCHED_TIMEOUT_EN defined, a watchdog SHALL count enabled cycles in DRAIN without deint_out_strobe; on reaching TIMEOUT_CYCLES it SHALL set err[1] and enter ERROR.
REQ-031 Without DEINT_SCHED_TIMEOUT_EN, the watchdog SHALL be absent, err[1] SHALL be tied 0, and DRAIN SHALL wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the state enum, the N_DC constants (48/52), the modulation enum, and the rate-to-N_BPSC decode function, which is shared with the deinterleaver.
REQ-033 One sub-module, deint_rate_decode, SHALL register the decoded N_BPSC, N_DC, drain target and supported flag at start.

Verification
REQ-034 Legacy BPSK (rate 0x0B), num_sym 2: exactly 48 deint_strobe, then 24 out strobes -> sym_done; repeat -> sym_done + pkt_done on the same cycle.
REQ-035 HT 64QAM (rate 0x87), num_sym 1 -> 52 carriers accepted, 156 out strobes, pkt_done 1 cycle after the 156th strobe.
REQ-036 in_strobe held high during DRAIN -> in_ready = 0, no deint_strobe, carrier counter unchanged.
REQ-037 Unsupported rate 0x05 -> err = 01, ERROR state, busy = 1; next start with a valid rate clears err.
REQ-038 With the macro defined, TIMEOUT_CYCLES = 16 and no out strobes -> err[1] set 16 cycles into DRAIN; without the macro, the block remains in DRAIN.
REQ-039 Reset asserted mid-FILL, and separately start during DRAIN -> counters cleared, no done pulses, new packet runs correctly.
